// File: rtl/debug_frame_serializer.sv
// Transmit-side framer for the debug UART link: captures one pipeline snapshot and
// sends it to uart_tx as SOF, payload bytes (most significant first), XOR checksum.
module debug_frame_serializer #(
  parameter int                NB_DATA = 8,
  parameter int                NB_WORD = 280,
  parameter int                NB_IDX  = 6,
  parameter logic [NB_DATA-1:0] SOF    = 8'hA5
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [NB_WORD-1:0] i_word,
  input  logic               i_txDone,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_IDX-1:0]  o_byte_idx
);

  localparam int N = NB_WORD / NB_DATA;
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N + 1);

  // Reject instantiations whose geometry cannot be framed.
  if (NB_WORD == 0 || (NB_WORD % NB_DATA) != 0) begin : g_bad_word
    $error("debug_frame_serializer: NB_WORD must be a nonzero multiple of NB_DATA");
  end
  if ((64'd1 << NB_IDX) < 64'(N + 2)) begin : g_bad_idx
    $error("debug_frame_serializer: NB_IDX too narrow for N+2 byte indices");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [NB_WORD-1:0] shift_reg, shift_next;
  logic [NB_DATA-1:0] csum_reg, csum_next;
  logic [NB_IDX-1:0]  idx_reg, idx_next;
  logic [NB_DATA-1:0] top_byte;
  logic               is_payload;

  assign top_byte   = shift_reg[NB_WORD-1 -: NB_DATA];
  assign is_payload = (idx_reg != '0) && (idx_reg != LAST_IDX);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      shift_reg <= '0;
      csum_reg  <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      csum_reg  <= csum_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    csum_next  = csum_reg;
    idx_next   = idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          shift_next = i_word;
          csum_next  = '0;
          idx_next   = '0;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_txDone) begin
          // The checksum lands on the same edge the index reaches N+1, so the
          // following SEND cycle already drives the final XOR.
          if (is_payload) begin
            csum_next  = csum_reg ^ top_byte;
            shift_next = shift_reg << NB_DATA;
          end
          if (idx_reg == LAST_IDX) begin
            state_next = ST_DONE;
          end else begin
            idx_next   = idx_reg + NB_IDX'(1);
            state_next = ST_SEND;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // o_data only changes on the edge that enters SEND, so it holds through WAIT.
  always_comb begin
    o_data = '0;
    if (state_reg == ST_SEND || state_reg == ST_WAIT) begin
      if (idx_reg == '0) begin
        o_data = SOF;
      end else if (idx_reg == LAST_IDX) begin
        o_data = csum_reg;
      end else begin
        o_data = top_byte;
      end
    end
  end

  assign o_tx_start = (state_reg == ST_SEND);
  assign o_busy     = (state_reg != ST_IDLE);
  assign o_done     = (state_reg == ST_DONE);
  assign o_byte_idx = idx_reg;

endmodule

// File: tb/tb_debug_frame_serializer.sv
// Bench for debug_frame_serializer: table of known snapshots, random frames against
// a byte-list reference model, and hand-written reset / noise / back-to-back cases.
module tb_debug_frame_serializer;
  localparam int NB_DATA = 8;
  localparam int NB_WORD = 280;
  localparam int NB_IDX  = 6;
  localparam int N       = NB_WORD / NB_DATA;
  localparam int TMO     = 64;
  localparam logic [7:0] SOF_B = 8'hA5;

  logic               clk = 1'b0;
  logic               i_rst;
  logic               i_start;
  logic [NB_WORD-1:0] i_word;
  logic               i_txDone;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_data;
  logic               o_busy;
  logic               o_done;
  logic [NB_IDX-1:0]  o_byte_idx;

  int n_checks = 0;
  int n_pass   = 0;
  int tx_count = 0;
  int done_count = 0;

  debug_frame_serializer dut (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_word    (i_word),
    .i_txDone  (i_txDone),
    .o_tx_start(o_tx_start),
    .o_data    (o_data),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_byte_idx(o_byte_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_tx_start) tx_count++;
    if (o_done) done_count++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [NB_WORD-1:0] rand_word();
    logic [NB_WORD-1:0] w;
    w = '0;
    for (int k = 0; k < N; k++) w[8*k +: 8] = 8'($urandom);
    return w;
  endfunction

  // Waits (bounded) for the next tx_start pulse; latency must be zero cycles.
  task automatic wait_tx(input string tag);
    int wt;
    wt = 0;
    while (!o_tx_start && wt < TMO) begin
      @(negedge clk);
      wt++;
    end
    chk({tag, " tx_start latency"}, 32'(wt), 32'd0);
  endtask

  task automatic send_frame(input logic [NB_WORD-1:0] w, input int ack_lo, input int ack_hi,
                            input bit noise, output logic [7:0] csum_got);
    logic [7:0] exp_q[$];
    logic [7:0] cs, d;
    logic [NB_IDX-1:0] ix;
    int tx0, dn0, hold_err, dly;
    // Reference frame: SOF, bytes from the top of the word down, XOR of payload.
    exp_q = {};
    exp_q.push_back(SOF_B);
    cs = 8'h00;
    for (int k = 0; k < N; k++) begin
      exp_q.push_back(w[NB_WORD-1-8*k -: 8]);
      cs ^= w[NB_WORD-1-8*k -: 8];
    end
    exp_q.push_back(cs);
    tx0 = tx_count;
    dn0 = done_count;
    hold_err = 0;
    csum_got = 8'h00;
    i_word  = w;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_word  = rand_word();
    chk("busy after start", 32'(o_busy), 32'd1);
    for (int b = 0; b < N + 2; b++) begin
      wait_tx($sformatf("byte%0d", b));
      chk($sformatf("byte%0d data", b), 32'(o_data), 32'(exp_q[b]));
      chk($sformatf("byte%0d idx", b), 32'(o_byte_idx), 32'(b));
      d  = o_data;
      ix = o_byte_idx;
      dly = int'($urandom_range(ack_hi, ack_lo));
      repeat (dly) begin
        @(negedge clk);
        if (noise) begin
          i_start = 1'b1;
          i_word  = rand_word();
        end
        if (o_data !== d || o_byte_idx !== ix || o_tx_start !== 1'b0) hold_err++;
      end
      i_start  = 1'b0;
      i_txDone = 1'b1;
      @(negedge clk);
      i_txDone = 1'b0;
      csum_got = d;
    end
    chk("done pulse", 32'(o_done), 32'd1);
    if (noise) i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("busy after done", 32'(o_busy), 32'd0);
    chk("done one cycle", 32'(o_done), 32'd0);
    if (noise) repeat (4) @(negedge clk);
    chk("hold during wait", 32'(hold_err), 32'd0);
    chk("tx_start count", 32'(tx_count - tx0), 32'(N + 2));
    chk("done count", 32'(done_count - dn0), 32'd1);
  endtask

  typedef struct {
    logic [NB_WORD-1:0] word;
    logic [7:0]         exp_csum;
  } vec_t;

  initial begin
    vec_t tbl[5];
    logic [7:0] cs_got;
    logic [NB_IDX-1:0] idx0;
    int tx0;

    tbl[0].word = {NB_WORD{1'b1}};           tbl[0].exp_csum = 8'hFF;
    tbl[1].word = '0;
    for (int k = 0; k < N; k++) tbl[1].word[NB_WORD-1-8*k -: 8] = 8'(k + 1);
    tbl[1].exp_csum = 8'h00;                 // XOR of 1..35
    tbl[2].word = '0;                        tbl[2].exp_csum = 8'h00;
    tbl[3].word = NB_WORD'(16'h1234);        tbl[3].exp_csum = 8'h26;
    tbl[4].word = NB_WORD'(8'hA5);           tbl[4].exp_csum = 8'hA5;

    i_rst = 1'b1; i_start = 1'b0; i_txDone = 1'b0; i_word = '0;
    repeat (3) @(negedge clk);
    chk("reset tx_start", 32'(o_tx_start), 32'd0);
    chk("reset data", 32'(o_data), 32'd0);
    chk("reset busy", 32'(o_busy), 32'd0);
    chk("reset done", 32'(o_done), 32'd0);
    chk("reset idx", 32'(o_byte_idx), 32'd0);
    i_rst = 1'b0;
    @(negedge clk);

    // Table frames run back to back: each start lands two cycles after o_done.
    for (int t = 0; t < 5; t++) begin
      send_frame(tbl[t].word, 1, 10, 1'b0, cs_got);
      chk($sformatf("table%0d checksum", t), 32'(cs_got), 32'(tbl[t].exp_csum));
    end

    // Spurious i_txDone while idle.
    idx0 = o_byte_idx;
    tx0  = tx_count;
    i_txDone = 1'b1;
    repeat (3) @(negedge clk);
    i_txDone = 1'b0;
    @(negedge clk);
    chk("idle txDone no start", 32'(tx_count - tx0), 32'd0);
    chk("idle txDone busy", 32'(o_busy), 32'd0);
    chk("idle txDone idx", 32'(o_byte_idx), 32'(idx0));

    // Restart requests mid-frame and on the done cycle are dropped.
    send_frame(rand_word(), 2, 6, 1'b1, cs_got);

    // Reset while waiting on byte 5.
    tx0 = tx_count;
    i_word  = rand_word();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int b = 0; b < 5; b++) begin
      wait_tx($sformatf("rst byte%0d", b));
      repeat (3) @(negedge clk);
      i_txDone = 1'b1;
      @(negedge clk);
      i_txDone = 1'b0;
    end
    wait_tx("rst byte5");
    chk("rst byte5 idx", 32'(o_byte_idx), 32'd5);
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    chk("midrst tx_start", 32'(o_tx_start), 32'd0);
    chk("midrst data", 32'(o_data), 32'd0);
    chk("midrst busy", 32'(o_busy), 32'd0);
    chk("midrst done", 32'(o_done), 32'd0);
    chk("midrst idx", 32'(o_byte_idx), 32'd0);
    i_txDone = 1'b1;
    @(negedge clk);
    i_txDone = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst no restart", 32'(tx_count - tx0), 32'd6);
    send_frame(tbl[3].word, 1, 4, 1'b0, cs_got);
    chk("post-reset checksum", 32'(cs_got), 32'h26);

    // Randomised frames against the reference model.
    for (int r = 0; r < 6; r++) send_frame(rand_word(), 1, 12, 1'b0, cs_got);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
